// File: rtl/mem_refill_responder.sv
// mem_refill_responder: word-array backing store that answers cache
// line refills with a 4-beat burst after a programmable wait.
module mem_refill_responder #(
  parameter int ADR_WIDTH  = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_AW     = 10,
  parameter int BEATS      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_cc2mem,
  input  logic [ADR_WIDTH-1:0]  adr_cc2mem,
  output logic                  ack_mem2cc,
  output logic [DATA_WIDTH-1:0] dat_mem2cc,
  input  logic [3:0]            lat_cfg,
  input  logic                  wr_en,
  input  logic [MEM_AW-1:0]     wr_adr,
  input  logic [DATA_WIDTH-1:0] wr_dat,
  output logic                  busy,
  output logic [15:0]           refill_cnt
);

  localparam int LW = $clog2(BEATS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_BURST = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [DATA_WIDTH-1:0] mem_q [2**MEM_AW];

  logic [1:0]           state_q, state_d;
  logic [MEM_AW-LW-1:0] line_q, line_d;
  logic [3:0]           wcnt_q, wcnt_d;
  logic [LW-1:0]        beat_q, beat_d;
  logic                 ack_q, ack_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic                 busy_q;
  logic [15:0]          cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rd_word;

  logic unused_adr;
  assign unused_adr = ^{adr_cc2mem[ADR_WIDTH-1:MEM_AW+2],
                        adr_cc2mem[LW+1:0]};

  // Read sees the pre-write contents on a same-word collision
  assign rd_word = mem_q[{line_q, beat_q}];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_adr] <= wr_dat;
    end
  end

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    wcnt_d  = wcnt_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    dat_d   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (req_cc2mem) begin
          line_d  = adr_cc2mem[MEM_AW+1:LW+2];
          wcnt_d  = lat_cfg;
          beat_d  = '0;
          state_d = (lat_cfg == 4'd0) ? S_BURST : S_WAIT;
        end
      end
      S_WAIT: begin
        wcnt_d = wcnt_q - 4'd1;
        if (wcnt_q <= 4'd1) begin
          state_d = S_BURST;
        end
      end
      S_BURST: begin
        ack_d  = 1'b1;
        dat_d  = rd_word;
        beat_d = beat_q + 1'b1;
        if (beat_q == LW'(BEATS - 1)) begin
          cnt_d   = cnt_q + 16'd1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!req_cc2mem) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      line_q  <= '0;
      wcnt_q  <= '0;
      beat_q  <= '0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      wcnt_q  <= wcnt_d;
      beat_q  <= beat_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      busy_q  <= (state_q != S_IDLE);
      cnt_q   <= cnt_d;
    end
  end

  assign ack_mem2cc = ack_q;
  assign dat_mem2cc = dat_q;
  assign busy       = busy_q;
  assign refill_cnt = cnt_q;

endmodule

// File: tb/tb_mem_refill_responder.sv
// Bench for mem_refill_responder: schedule-based reference model
// compared every cycle, plus directed literal checks.
module tb_mem_refill_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_cc2mem = 1'b0;
  logic [31:0] adr_cc2mem = '0;
  logic        ack_mem2cc;
  logic [31:0] dat_mem2cc;
  logic [3:0]  lat_cfg = '0;
  logic        wr_en = 1'b0;
  logic [9:0]  wr_adr = '0;
  logic [31:0] wr_dat = '0;
  logic        busy;
  logic [15:0] refill_cnt;

  int n_chk = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  mem_refill_responder dut (
    .clk(clk),
    .rst(rst),
    .req_cc2mem(req_cc2mem),
    .adr_cc2mem(adr_cc2mem),
    .ack_mem2cc(ack_mem2cc),
    .dat_mem2cc(dat_mem2cc),
    .lat_cfg(lat_cfg),
    .wr_en(wr_en),
    .wr_adr(wr_adr),
    .wr_dat(wr_dat),
    .busy(busy),
    .refill_cnt(refill_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a refill accepted at edge n gives beat k in
  // cycle n+1+lat+k; the line is released at the first edge from
  // n+lat+5 on where the request is low.
  logic [31:0] mmem [1024];
  logic        m_active = 1'b0;
  int          m_acc = 0;
  int          m_lat = 0;
  int          m_rel = -100;
  int          cyc = 0;
  logic [9:0]  m_base = '0;
  logic        exp_ack = 1'b0;
  logic [31:0] exp_dat = '0;
  logic        exp_busy = 1'b0;
  logic [15:0] exp_cnt = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active = 1'b0;
      m_rel    = -100;
      exp_ack  = 1'b0;
      exp_dat  = '0;
      exp_busy = 1'b0;
      exp_cnt  = '0;
    end else begin
      int n;
      int k;
      cyc++;
      n = cyc;
      exp_ack = 1'b0;
      exp_dat = '0;
      if (m_active) begin
        k = n - m_acc - 1 - m_lat;
        if (k >= 0 && k <= 3) begin
          exp_ack = 1'b1;
          exp_dat = mmem[int'(m_base) + k];
          if (k == 3) exp_cnt = exp_cnt + 16'd1;
        end
        if (n >= m_acc + m_lat + 5 && !req_cc2mem) begin
          m_active = 1'b0;
          m_rel    = n;
        end
      end else if (req_cc2mem) begin
        m_active = 1'b1;
        m_acc    = n;
        m_lat    = int'(lat_cfg);
        m_base   = {adr_cc2mem[11:4], 2'b00};
      end
      exp_busy = (m_active && n > m_acc) || (n == m_rel);
      if (wr_en) mmem[wr_adr] = wr_dat;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_ack", 32'(ack_mem2cc), 32'(exp_ack));
      chk("model_dat", dat_mem2cc, exp_dat);
      chk("model_busy", 32'(busy), 32'(exp_busy));
      chk("model_cnt", 32'(refill_cnt), 32'(exp_cnt));
    end
  end

  // Starts at a negedge with the DUT idle; ends one cycle after req drops.
  task automatic burst(input logic [31:0] adr, input logic [3:0] lat,
                       input logic [31:0] e0, input logic [31:0] e1,
                       input logic [31:0] e2, input logic [31:0] e3,
                       input int hold, input int wj, input string nm);
    int b;
    logic [31:0] ev;
    adr_cc2mem = adr;
    lat_cfg    = lat;
    req_cc2mem = 1'b1;
    @(posedge clk);
    @(negedge clk);
    adr_cc2mem = $urandom;
    lat_cfg    = 4'($urandom);
    for (int j = 1; j <= int'(lat) + 4 + hold; j++) begin
      @(negedge clk);
      b = j - int'(lat) - 1;
      if (b >= 0 && b <= 3) begin
        case (b)
          0: ev = e0;
          1: ev = e1;
          2: ev = e2;
          default: ev = e3;
        endcase
        chk({nm, "_ack"}, 32'(ack_mem2cc), 32'd1);
        chk({nm, "_dat"}, dat_mem2cc, ev);
      end else begin
        chk({nm, "_noack"}, 32'(ack_mem2cc), 32'd0);
      end
      wr_en = (j == wj);
      if (j == wj) begin
        wr_adr = 10'h341;
        wr_dat = 32'h1234_5678;
      end
    end
    wr_en      = 1'b0;
    req_cc2mem = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    @(posedge clk);
    chk_en = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_ack", 32'(ack_mem2cc), 32'd0);
    chk("rst_dat", dat_mem2cc, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt", 32'(refill_cnt), 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_ack", 32'(ack_mem2cc), 32'd0);

    for (int i = 0; i < 1024; i++) begin
      wr_en  = 1'b1;
      wr_adr = 10'(i);
      if (i >= 'h340 && i <= 'h343) wr_dat = 32'hA000_0000 + 32'(i - 'h340);
      else wr_dat = $urandom;
      @(negedge clk);
    end
    wr_en = 1'b0;

    burst(32'hFF07_BD08, 4'd3, 32'hA000_0000, 32'hA000_0001,
          32'hA000_0002, 32'hA000_0003, 0, -1, "basic");
    chk("basic_cnt", 32'(refill_cnt), 32'd1);

    burst(32'hD500_AD00, 4'd0, 32'hA000_0000, 32'hA000_0001,
          32'hA000_0002, 32'hA000_0003, 10, -1, "zlat_held");
    chk("held_cnt", 32'(refill_cnt), 32'd2);

    burst(32'hD500_AD00, 4'd0, 32'hA000_0000, 32'hA000_0001,
          32'hA000_0002, 32'hA000_0003, 0, -1, "rerequest");
    chk("rereq_cnt", 32'(refill_cnt), 32'd3);

    adr_cc2mem = 32'hFF07_BD08;
    lat_cfg    = 4'd2;
    req_cc2mem = 1'b1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_ack", 32'(ack_mem2cc), 32'd0);
    chk("midrst_dat", dat_mem2cc, 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_cnt", 32'(refill_cnt), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    burst(32'hFF07_BD08, 4'd2, 32'hA000_0000, 32'hA000_0001,
          32'hA000_0002, 32'hA000_0003, 0, -1, "after_rst");
    chk("after_rst_cnt", 32'(refill_cnt), 32'd1);

    burst(32'h0000_0D00, 4'd1, 32'hA000_0000, 32'hA000_0001,
          32'hA000_0002, 32'hA000_0003, 0, 2, "collide");
    burst(32'h0000_0D04, 4'd1, 32'hA000_0000, 32'h1234_5678,
          32'hA000_0002, 32'hA000_0003, 0, -1, "post_wr");
    chk("post_wr_cnt", 32'(refill_cnt), 32'd3);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 599) == 0) begin
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) req_cc2mem = ~req_cc2mem;
      adr_cc2mem = $urandom;
      if ($urandom_range(0, 1) == 1)
        adr_cc2mem[11:4] = 8'hD0 + 8'($urandom_range(0, 1));
      lat_cfg = ($urandom_range(0, 9) == 0) ? 4'd15
                                             : 4'($urandom_range(0, 4));
      wr_en  = ($urandom_range(0, 3) == 0);
      wr_adr = ($urandom_range(0, 1) == 1)
               ? 10'h340 + 10'($urandom_range(0, 7)) : 10'($urandom);
      wr_dat = $urandom;
    end
    @(negedge clk);
    req_cc2mem = 1'b0;
    wr_en      = 1'b0;
    repeat (25) @(negedge clk);
    chk("final_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
